// File: rtl/register_file_nr_nw_clr.sv
`default_nettype none
// ============================================================================
// Module      : register_file_nr_nw_clr
// Description : Flip-flop register file with N_READ combinational read ports,
//               N_WRITE byte-enabled write ports (highest port index wins per
//               byte) and a sequential clear engine that zeroes one word per
//               cycle.
//
// Ports       : clk         clock
//               rst_n       asynchronous active-low reset
//               raddr_i     [N_READ] read addresses
//               rdata_o     [N_READ] read data (combinational)
//               waddr_i     [N_WRITE] write addresses
//               wdata_i     [N_WRITE] write data
//               wbe_i       [N_WRITE] write byte enables
//               we_i        [N_WRITE] write requests
//               wgnt_o      [N_WRITE] write grants (we_i while not sweeping)
//               clr_req_i   clear request, sampled in IDLE only
//               clr_busy_o  clear sweep in progress
//               clr_done_o  one-cycle pulse after the last word is cleared
//
// Options     : RF_NRNW_WRITE_BYPASS_EN - when defined, reads are write-first
//               (granted writes to the read address appear combinationally
//               on rdata_o). When undefined, reads return pre-edge contents.
//
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_nr_nw_clr #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int N_READ     = 2,
    parameter int N_WRITE    = 2
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [N_READ-1:0][ADDR_WIDTH-1:0]       raddr_i,
    output logic [N_READ-1:0][DATA_WIDTH-1:0]       rdata_o,
    input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]      waddr_i,
    input  logic [N_WRITE-1:0][DATA_WIDTH-1:0]      wdata_i,
    input  logic [N_WRITE-1:0][DATA_WIDTH/8-1:0]    wbe_i,
    input  logic [N_WRITE-1:0]                      we_i,
    output logic [N_WRITE-1:0]                      wgnt_o,
    input  logic                                    clr_req_i,
    output logic                                    clr_busy_o,
    output logic                                    clr_done_o
);

    localparam int C_NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int C_BE_WIDTH  = DATA_WIDTH / 8;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_SWEEP = 2'd1;
    localparam logic [1:0] C_ST_DONE  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q,   cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [C_NUM_WORDS];
    logic [DATA_WIDTH-1:0] mem_d [C_NUM_WORDS];

    logic                  w_busy;
    logic                  w_done;
    logic [N_WRITE-1:0]    w_gnt;

    // ------------------------------------------------------------------
    // Clear FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Clear FSM: next state. The sweep visits every word exactly once;
    // the all-ones counter value marks the last word.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            C_ST_IDLE: begin
                if (clr_req_i) begin
                    state_d = C_ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            C_ST_SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = C_ST_DONE;
                end
            end
            C_ST_DONE: begin
                state_d = C_ST_IDLE;
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Clear FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_busy = (state_q == C_ST_SWEEP);
        w_done = (state_q == C_ST_DONE);
    end

    // Writes are refused for the whole sweep so no word can be re-dirtied
    // behind the sweep pointer. Grants are also held off while in reset so
    // every output reads 0 during reset.
    assign w_gnt      = we_i & {N_WRITE{~w_busy & rst_n}};
    assign wgnt_o     = w_gnt;
    assign clr_busy_o = w_busy;
    assign clr_done_o = w_done;

    // ------------------------------------------------------------------
    // Array next state. Ports are applied in ascending order so the
    // highest-index port overwrites lower ones byte by byte; ports with
    // disjoint byte enables on the same word all land.
    // ------------------------------------------------------------------
    always_comb begin
        for (int w = 0; w < C_NUM_WORDS; w++) begin
            mem_d[w] = mem_q[w];
        end
        for (int p = 0; p < N_WRITE; p++) begin
            for (int b = 0; b < C_BE_WIDTH; b++) begin
                if (w_gnt[p] && wbe_i[p][b]) begin
                    mem_d[waddr_i[p]][b*8 +: 8] = wdata_i[p][b*8 +: 8];
                end
            end
        end
        if (w_busy) begin
            mem_d[cnt_q] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < C_NUM_WORDS; w++) begin
                mem_q[w] <= '0;
            end
        end else begin
            for (int w = 0; w < C_NUM_WORDS; w++) begin
                mem_q[w] <= mem_d[w];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar r = 0; r < N_READ; r++) begin : g_rd
`ifdef RF_NRNW_WRITE_BYPASS_EN
        // Write-first: merge only granted port writes, never the sweep
        // zeroing (writes are never granted during a sweep anyway).
        logic [DATA_WIDTH-1:0] w_rd;
        always_comb begin
            w_rd = mem_q[raddr_i[r]];
            for (int p = 0; p < N_WRITE; p++) begin
                for (int b = 0; b < C_BE_WIDTH; b++) begin
                    if (w_gnt[p] && wbe_i[p][b] && (waddr_i[p] == raddr_i[r])) begin
                        w_rd[b*8 +: 8] = wdata_i[p][b*8 +: 8];
                    end
                end
            end
        end
        assign rdata_o[r] = w_rd;
`else
        assign rdata_o[r] = mem_q[raddr_i[r]];
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_register_file_nr_nw_clr.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_nr_nw_clr
// Description : Self-checking bench for register_file_nr_nw_clr. A word-array
//               model with a simple sweep pointer predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_nr_nw_clr;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int NR  = 2;
    localparam int NW  = 2;
    localparam int BEW = DW / 8;
    localparam int NWORDS = 2 ** AW;

    logic                     clk;
    logic                     rst_n;
    logic [NR-1:0][AW-1:0]    raddr;
    logic [NR-1:0][DW-1:0]    rdata;
    logic [NW-1:0][AW-1:0]    waddr;
    logic [NW-1:0][DW-1:0]    wdata;
    logic [NW-1:0][BEW-1:0]   wbe;
    logic [NW-1:0]            we;
    logic [NW-1:0]            wgnt;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;

    int checks;
    int errors;

    // Reference model: word array plus sweep position
    logic [DW-1:0] model_mem [NWORDS];
    bit            m_busy;
    bit            m_done;
    int            m_idx;

    register_file_nr_nw_clr #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .N_READ     (NR),
        .N_WRITE    (NW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raddr_i    (raddr),
        .rdata_o    (rdata),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .wbe_i      (wbe),
        .we_i       (we),
        .wgnt_o     (wgnt),
        .clr_req_i  (clr_req),
        .clr_busy_o (clr_busy),
        .clr_done_o (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    task automatic model_reset();
        for (int w = 0; w < NWORDS; w++) model_mem[w] = '0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_idx  = 0;
    endtask

    function automatic bit exp_gnt(int p);
        return (rst_n === 1'b1) && (we[p] === 1'b1) && !m_busy;
    endfunction

    // Port that owns byte b of word addr this cycle, searching from the top.
    function automatic int winner(int addr, int b);
        for (int p = NW - 1; p >= 0; p--) begin
            if (exp_gnt(p) && wbe[p][b] && (int'(waddr[p]) == addr)) return p;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] exp_rdata(int r);
        logic [DW-1:0] v;
        v = model_mem[raddr[r]];
`ifdef RF_NRNW_WRITE_BYPASS_EN
        for (int b = 0; b < BEW; b++) begin
            int wn;
            wn = winner(int'(raddr[r]), b);
            if (wn >= 0) v[b*8 +: 8] = wdata[wn][b*8 +: 8];
        end
`endif
        return v;
    endfunction

    function automatic logic [NW-1:0] exp_wgnt_vec();
        logic [NW-1:0] g;
        for (int p = 0; p < NW; p++) g[p] = exp_gnt(p);
        return g;
    endfunction

    // Advance one clock: model follows the inputs present before the edge.
    task automatic tick();
        logic [DW-1:0] nxt [NWORDS];
        bit nb, nd;
        int ni;
        nxt = model_mem;
        nb = m_busy; nd = m_done; ni = m_idx;
        if (rst_n === 1'b1) begin
            for (int w = 0; w < NWORDS; w++) begin
                for (int b = 0; b < BEW; b++) begin
                    int wn;
                    wn = winner(w, b);
                    if (wn >= 0) nxt[w][b*8 +: 8] = wdata[wn][b*8 +: 8];
                end
            end
            if (m_busy) begin
                nxt[m_idx] = '0;
                if (m_idx == NWORDS - 1) begin
                    nb = 1'b0; nd = 1'b1; ni = 0;
                end else begin
                    ni = m_idx + 1;
                end
            end else if (m_done) begin
                nd = 1'b0;
            end else if (clr_req) begin
                nb = 1'b1; ni = 0;
            end
        end
        @(posedge clk);
        if (rst_n === 1'b1) begin
            model_mem = nxt;
            m_busy = nb; m_done = nd; m_idx = ni;
        end
        #1;
    endtask

    task automatic idle_inputs();
        we = '0; wbe = '0; wdata = '0; waddr = '0; clr_req = 1'b0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < NWORDS / 2; i++) begin
            we = 2'b11;
            waddr[0] = AW'(2 * i);
            waddr[1] = AW'(2 * i + 1);
            wdata[0] = $urandom | 32'h1;
            wdata[1] = $urandom | 32'h1;
            wbe = {4'hF, 4'hF};
            tick();
        end
        idle_inputs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < NWORDS / 2; i++) begin
            raddr[0] = AW'(2 * i);
            raddr[1] = AW'(NWORDS - 1 - 2 * i);
            @(negedge clk);
            checks++;
            if (rdata[0] !== '0 || rdata[1] !== '0) begin
                errors++;
                $display("FAIL reset_rdata i=%0d got %h %h want 0", i, rdata[0], rdata[1]);
            end
            checks++;
            if (clr_busy !== 1'b0 || clr_done !== 1'b0 || wgnt !== '0) begin
                errors++;
                $display("FAIL reset_ctrl got busy=%b done=%b wgnt=%b want 0", clr_busy, clr_done, wgnt);
            end
            tick();
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_write_priority();
        we = 2'b11; waddr[0] = 5'd3; waddr[1] = 5'd3;
        wdata[0] = 32'hAAAAAAAA; wdata[1] = 32'h55555555; wbe = {4'hF, 4'hF};
        @(negedge clk);
        checks++;
        if (wgnt !== 2'b11) begin
            errors++;
            $display("FAIL prio_wgnt got %b want 11", wgnt);
        end
        tick();
        idle_inputs();
        raddr[0] = 5'd3; raddr[1] = 5'd3;
        @(negedge clk);
        checks++;
        if (rdata[0] !== 32'h55555555 || rdata[1] !== 32'h55555555) begin
            errors++;
            $display("FAIL prio_data got %h %h want 55555555", rdata[0], rdata[1]);
        end
        tick();
    endtask

    task automatic test_byte_merge();
        we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
        wdata[0] = 32'h11223344; wdata[1] = 32'hAABBCCDD;
        wbe[0] = 4'b0011; wbe[1] = 4'b1100;
        tick();
        idle_inputs();
        raddr[0] = 5'd7;
        @(negedge clk);
        checks++;
        if (rdata[0] !== 32'hAABB3344) begin
            errors++;
            $display("FAIL byte_merge got %h want aabb3344", rdata[0]);
        end
        tick();
    endtask

    task automatic test_zero_be();
        we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
        wdata[0] = $urandom; wdata[1] = $urandom; wbe = '0;
        raddr[1] = 5'd7;
        @(negedge clk);
        checks++;
        if (wgnt !== 2'b11 || rdata[1] !== 32'hAABB3344) begin
            errors++;
            $display("FAIL zero_be_same got wgnt=%b data=%h want 11 aabb3344", wgnt, rdata[1]);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (rdata[1] !== 32'hAABB3344) begin
            errors++;
            $display("FAIL zero_be_hold got %h want aabb3344", rdata[1]);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < NW; p++) begin
                we[p]    = 1'($urandom_range(0, 1));
                waddr[p] = AW'($urandom_range(0, 7));
                wdata[p] = $urandom;
                wbe[p]   = BEW'($urandom_range(0, 15));
            end
            for (int r = 0; r < NR; r++) begin
                raddr[r] = (c % 2 == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NWORDS - 1));
            end
            @(negedge clk);
            checks++;
            if (wgnt !== exp_wgnt_vec()) begin
                errors++;
                $display("FAIL rand_wgnt c=%0d got %b want %b", c, wgnt, exp_wgnt_vec());
            end
            for (int r = 0; r < NR; r++) begin
                checks++;
                if (rdata[r] !== exp_rdata(r)) begin
                    errors++;
                    $display("FAIL rand_rdata c=%0d port=%0d addr=%0d got %h want %h",
                             c, r, raddr[r], rdata[r], exp_rdata(r));
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        int busy_cnt, done_cnt;
        bit seen_done;
        busy_cnt = 0; done_cnt = 0; seen_done = 1'b0;
        fill_all();
        clr_req = 1'b1;
        @(negedge clk);
        checks++;
        if (clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_req_cycle got busy=%b want 0", clr_busy);
        end
        tick();
        clr_req = 1'b0;
        we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'h0000DEAD; wbe[0] = 4'hF;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            raddr[0] = AW'($urandom_range(0, NWORDS - 1));
            raddr[1] = AW'($urandom_range(0, NWORDS - 1));
            clr_req = (c % 7 == 3);
            @(negedge clk);
            checks++;
            if (clr_busy !== m_busy || clr_done !== m_done) begin
                errors++;
                $display("FAIL sweep_ctrl c=%0d got busy=%b done=%b want %b %b",
                         c, clr_busy, clr_done, m_busy, m_done);
            end
            for (int r = 0; r < NR; r++) begin
                checks++;
                if (rdata[r] !== exp_rdata(r)) begin
                    errors++;
                    $display("FAIL sweep_rdata c=%0d addr=%0d got %h want %h",
                             c, raddr[r], rdata[r], exp_rdata(r));
                end
            end
            if (clr_busy === 1'b1) begin
                busy_cnt++;
                checks++;
                if (wgnt[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_wgnt c=%0d got %b want 0", c, wgnt[0]);
                end
            end
            if (clr_done === 1'b1) begin
                done_cnt++;
                seen_done = 1'b1;
                checks++;
                if (wgnt[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL done_wgnt got %b want 1", wgnt[0]);
                end
            end
            tick();
        end
        idle_inputs();
        checks++;
        if (busy_cnt != NWORDS) begin
            errors++;
            $display("FAIL sweep_len got %0d want %0d", busy_cnt, NWORDS);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL done_pulses got %0d want 1", done_cnt);
        end
        for (int i = 0; i < NWORDS / 2; i++) begin
            raddr[0] = AW'(2 * i);
            raddr[1] = AW'(2 * i + 1);
            @(negedge clk);
            for (int r = 0; r < NR; r++) begin
                checks++;
                if (rdata[r] !== ((int'(raddr[r]) == 5) ? 32'h0000DEAD : 32'h0)) begin
                    errors++;
                    $display("FAIL post_clear addr=%0d got %h want %h", raddr[r], rdata[r],
                             (int'(raddr[r]) == 5) ? 32'h0000DEAD : 32'h0);
                end
            end
            checks++;
            if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
                errors++;
                $display("FAIL post_clear_ctrl got busy=%b done=%b want 0 0", clr_busy, clr_done);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        we = 2'b10; waddr[1] = 5'd9; wdata[1] = 32'h12345678; wbe[1] = 4'hF;
        tick();
        idle_inputs();
        we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'hCAFEF00D; wbe[0] = 4'hF;
        raddr[0] = 5'd9; raddr[1] = 5'd9;
        @(negedge clk);
        checks++;
`ifdef RF_NRNW_WRITE_BYPASS_EN
        if (rdata[0] !== 32'hCAFEF00D || rdata[1] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL bypass_same got %h %h want cafef00d", rdata[0], rdata[1]);
        end
`else
        if (rdata[0] !== 32'h12345678 || rdata[1] !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_same got %h %h want 12345678", rdata[0], rdata[1]);
        end
`endif
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (rdata[0] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL bypass_next got %h want cafef00d", rdata[0]);
        end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        fill_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        @(negedge clk);
        checks++;
        if (clr_busy !== 1'b1 || m_idx != 10) begin
            errors++;
            $display("FAIL mid_sweep_busy got %b want 1 (model idx %0d)", clr_busy, m_idx);
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ctrl got busy=%b done=%b want 0 0", clr_busy, clr_done);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NWORDS / 2; i++) begin
            raddr[0] = AW'(2 * i);
            raddr[1] = AW'(2 * i + 1);
            @(negedge clk);
            checks++;
            if (rdata[0] !== '0 || rdata[1] !== '0) begin
                errors++;
                $display("FAIL mid_reset_zero i=%0d got %h %h want 0", i, rdata[0], rdata[1]);
            end
            checks++;
            if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_idle got busy=%b done=%b want 0 0", clr_busy, clr_done);
            end
            tick();
        end
        // A fresh clear must be accepted, proving the FSM is in IDLE.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (clr_busy !== 1'b1) begin
            errors++;
            $display("FAIL reclear_busy got %b want 1", clr_busy);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        raddr  = '0;
        idle_inputs();
        model_reset();
        #2;
        test_reset();
        test_write_priority();
        test_byte_merge();
        test_zero_be();
        test_random();
        test_clear();
        test_bypass();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
